// File: rtl/nand_phy_pkg.sv
// Shared encodings for the asynchronous-mode NAND bus sequencer: request opcodes,
// FSM states and the default timing-field width.
package nand_phy_pkg;

  localparam int TW_DEF = 4;

  typedef enum logic [1:0] {
    OP_CMD  = 2'd0,
    OP_ADDR = 2'd1,
    OP_DIN  = 2'd2,
    OP_DOUT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

endpackage

// File: rtl/nand_timing_cnt.sv
// Loadable down-counter for setup/pulse/hold phases. A load value of 0 acts as 1,
// and done is high while the count sits at 1 (the last cycle of the phase).
module nand_timing_cnt #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = (load_val == '0) ? TW'(1) : load_val;
    end else if (cnt_q > TW'(1)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= TW'(1);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == TW'(1));

endmodule

// File: rtl/nand_async_io_seq.sv
// Asynchronous (SDR) NAND bus sequencer: one request per handshake becomes a timed
// CE#/CLE/ALE/WE#/RE#/DQ waveform with runtime setup/pulse/hold counts.
module nand_async_io_seq
  import nand_phy_pkg::*;
#(
  parameter int DQ_WIDTH = 8,
  parameter int NUM_CE   = 2,
  parameter int CE_SEL_W = 1,
  parameter int TW       = TW_DEF
) (
  input  logic                v_clk0,
  input  logic                v_rst0,
  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both high; req_ready is high only in IDLE, so one request
  // is in flight at a time and the request fields are sampled on that edge.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [CE_SEL_W-1:0] req_ce,
  input  logic [DQ_WIDTH-1:0] req_data,
  input  logic                req_last,
  input  logic [TW-1:0]       cfg_tsetup,
  input  logic [TW-1:0]       cfg_tpulse,
  input  logic [TW-1:0]       cfg_thold,
  output logic                rd_valid,
  output logic [DQ_WIDTH-1:0] rd_data,
  output logic [NUM_CE-1:0]   v_cen,
  output logic                v_cle,
  output logic                v_ale,
  output logic                v_wen,
  output logic                v_ren,
  output logic [DQ_WIDTH-1:0] v_dq_out,
  output logic                v_dq_oe_n,
  input  logic [DQ_WIDTH-1:0] v_dq_in,
  output logic                busy,
  output state_e              dbg_state
);

  state_e              state_q,  state_d;
  op_e                 op_q,     op_d;
  logic                last_q,   last_d;
  logic [TW-1:0]       tpulse_q, tpulse_d;
  logic [TW-1:0]       thold_q,  thold_d;
  logic [NUM_CE-1:0]   cen_q,    cen_d;
  logic                cle_q,    cle_d;
  logic                ale_q,    ale_d;
  logic                wen_q,    wen_d;
  logic                ren_q,    ren_d;
  logic [DQ_WIDTH-1:0] dq_out_q, dq_out_d;
  logic                oe_n_q,   oe_n_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DQ_WIDTH-1:0] rd_data_q,  rd_data_d;
  logic                ready_q,  ready_d;

  logic                cnt_load;
  logic [TW-1:0]       cnt_val;
  logic                cnt_done;
  logic [NUM_CE-1:0]   ce_sel;

  // Out-of-range chip indices match no bit, so every CE# stays high.
  always_comb begin
    ce_sel = '1;
    for (int i = 0; i < NUM_CE; i++) begin
      if (int'(req_ce) == i) ce_sel[i] = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    last_d     = last_q;
    tpulse_d   = tpulse_q;
    thold_d    = thold_q;
    cen_d      = cen_q;
    cle_d      = cle_q;
    ale_d      = ale_q;
    wen_d      = wen_q;
    ren_d      = ren_q;
    dq_out_d   = dq_out_q;
    oe_n_d     = oe_n_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    cnt_load   = 1'b0;
    cnt_val    = cfg_tsetup;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d  = ST_SETUP;
          op_d     = op_e'(req_op);
          last_d   = req_last;
          tpulse_d = cfg_tpulse;
          thold_d  = cfg_thold;
          cnt_load = 1'b1;
          cnt_val  = cfg_tsetup;
          // Selecting a new chip releases any CE# left low by a non-last request.
          cen_d    = ce_sel;
          cle_d    = (req_op == OP_CMD);
          ale_d    = (req_op == OP_ADDR);
          oe_n_d   = (req_op == OP_DOUT);
          if (req_op != OP_DOUT) dq_out_d = req_data;
        end
      end
      ST_SETUP: begin
        if (cnt_done) begin
          state_d  = ST_STROBE;
          cnt_load = 1'b1;
          cnt_val  = tpulse_q;
          if (op_q == OP_DOUT) ren_d = 1'b0;
          else                 wen_d = 1'b0;
        end
      end
      ST_STROBE: begin
        if (cnt_done) begin
          state_d  = ST_HOLD;
          cnt_load = 1'b1;
          cnt_val  = thold_q;
          wen_d    = 1'b1;
          ren_d    = 1'b1;
          if (op_q == OP_DOUT) begin
            rd_data_d  = v_dq_in;
            rd_valid_d = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (cnt_done) begin
          state_d = ST_IDLE;
          cle_d   = 1'b0;
          ale_d   = 1'b0;
          oe_n_d  = 1'b1;
          if (last_q) cen_d = '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_CMD;
      last_q     <= 1'b0;
      tpulse_q   <= '0;
      thold_q    <= '0;
      cen_q      <= '1;
      cle_q      <= 1'b0;
      ale_q      <= 1'b0;
      wen_q      <= 1'b1;
      ren_q      <= 1'b1;
      dq_out_q   <= '0;
      oe_n_q     <= 1'b1;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      last_q     <= last_d;
      tpulse_q   <= tpulse_d;
      thold_q    <= thold_d;
      cen_q      <= cen_d;
      cle_q      <= cle_d;
      ale_q      <= ale_d;
      wen_q      <= wen_d;
      ren_q      <= ren_d;
      dq_out_q   <= dq_out_d;
      oe_n_q     <= oe_n_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      ready_q    <= ready_d;
    end
  end

  nand_timing_cnt #(.TW(TW)) u_cnt (
    .clk      (v_clk0),
    .rst      (v_rst0),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  assign req_ready = ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign v_cen     = cen_q;
  assign v_cle     = cle_q;
  assign v_ale     = ale_q;
  assign v_wen     = wen_q;
  assign v_ren     = ren_q;
  assign v_dq_out  = dq_out_q;
  assign v_dq_oe_n = oe_n_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
